pb_press_decoder: RTL and testbench
===================================

PB_PRESS_DECODER -- requirements
Module: pb_press_decoder

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, meaning the number of consecutive stable clocks needed to accept a level change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, meaning the number of debounced-pressed clocks that classify a press as long (1 s at 50 MHz); legal range 2..2^28-1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port PB_SW, input, 1 bit: raw push-button pin, asynchronous to CLK, active-low (0 = pressed).
REQ-006 SHALL have port PB_LEVEL, output, 1 bit: debounced button state (1 = pressed).
REQ-007 SHALL have port PRESS_PULSE, output, 1 bit: one-clock strobe on each debounced press.
REQ-008 SHALL have port RELEASE_PULSE, output, 1 bit: one-clock strobe on each debounced release.
REQ-009 SHALL have port SHORT_PULSE, output, 1 bit: one-clock strobe when a release ends a press shorter than LONG_CYCLES.
REQ-010 SHALL have port LONG_PULSE, output, 1 bit: one-clock strobe when a press reaches LONG_CYCLES.
REQ-011 SHALL have port HOLD, output, 1 bit: high while a long press is still held.
REQ-012 SHALL have port PRESS_COUNT, output, 8 bits: running count of debounced presses.

Function
REQ-013 SHALL pass PB_SW through a 2-flop synchronizer and invert it to give an active-high sample, sync_pb.
REQ-014 SHALL run a 24-bit debounce counter:
- Cleared whenever sync_pb equals PB_LEVEL.
- Incremented whenever they differ.
- On the clock where the counter equals DEB_CYCLES-1 and they still differ: PB_LEVEL toggles and the counter clears.
REQ-015 SHALL discard any bounce shorter than DEB_CYCLES clocks without changing PB_LEVEL or emitting any pulse.
REQ-016 SHALL register all outputs and assert PRESS_PULSE/RELEASE_PULSE on the same clock that PB_LEVEL changes.
- Latency from a clean PB_SW edge to the pulse is exactly DEB_CYCLES+2 clocks.
REQ-017 SHALL implement FSM states IDLE, PRESSED and LONG_HELD, with a 28-bit hold counter:
- IDLE -> PRESSED on a debounced press: assert PRESS_PULSE; hold counter cleared.
- PRESSED: hold counter increments every clock.
- PRESSED -> IDLE on a debounced release before the hold counter reaches LONG_CYCLES-1: assert SHORT_PULSE and RELEASE_PULSE together.
- PRESSED -> LONG_HELD on the clock the hold counter equals LONG_CYCLES-1: assert LONG_PULSE; HOLD rises on the same clock.
- LONG_HELD: hold counter frozen; no further LONG_PULSE.
- LONG_HELD -> IDLE on a debounced release: assert RELEASE_PULSE; HOLD falls on the same clock; no SHORT_PULSE.
REQ-018 SHALL resolve the simultaneous case: if a release is accepted on the same clock the hold counter reaches LONG_CYCLES-1, release wins.
- SHORT_PULSE and RELEASE_PULSE assert; LONG_PULSE does not.
REQ-019 SHALL increment PRESS_COUNT by 1 on each PRESS_PULSE, with modulo-256 wrap (255 -> 0).
REQ-020 SHALL never assert PRESS_PULSE and RELEASE_PULSE on the same clock.
- At most one of SHORT_PULSE/LONG_PULSE per press.

Reset
REQ-021 SHALL, while RESET is high, asynchronously force:
- Synchronizer flops to 1 (released).
- Debounce and hold counters to 0.
- FSM to IDLE.
- PB_LEVEL, all pulses and HOLD to 0; PRESS_COUNT to 0.
REQ-022 SHALL, on reset assertion mid-press, abandon the press silently: no RELEASE_PULSE/SHORT_PULSE after deassertion.
- A button still held at deassertion is re-debounced and produces a fresh PRESS_PULSE DEB_CYCLES+2 clocks later.

Verification (DEB_CYCLES=4, LONG_CYCLES=20)
REQ-023 SHALL cover a clean short press: PB_SW=0 for 10 clocks, then 1.
- PRESS_PULSE 6 clocks after the fall; SHORT_PULSE+RELEASE_PULSE 6 clocks after the rise; PRESS_COUNT=1.
REQ-024 SHALL cover bounce rejection: PB_SW toggles every 3 clocks for 30 clocks, then rests at 1.
- No pulses; PB_LEVEL=0 throughout.
REQ-025 SHALL cover a long press: PB_SW=0 for 40 clocks.
- LONG_PULSE exactly 19 clocks after PRESS_PULSE; HOLD=1 until release; RELEASE_PULSE only, no SHORT_PULSE.
REQ-026 SHALL cover the simultaneous boundary: a release timed to be accepted on the clock the hold counter reaches 19.
- SHORT_PULSE+RELEASE_PULSE; no LONG_PULSE; HOLD stays 0.
REQ-027 SHALL cover wrap-around: 256 clean presses.
- PRESS_COUNT returns to 0x00 after the 256th PRESS_PULSE.
REQ-028 SHALL cover reset mid-press: RESET pulsed during LONG_HELD with PB_SW held 0.
- Outputs 0 immediately; fresh PRESS_PULSE 6 clocks after deassertion; PRESS_COUNT=1.

Source files
------------

// File: rtl/pb_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pb_press_decoder
// Description : Push-button front end. Synchronises and debounces an
//               active-low button pin, then classifies each press as short
//               or long. All outputs are registered.
// Ports       : CLK           - rising-edge clock
//               RESET         - asynchronous active-high reset
//               PB_SW         - raw button pin, active-low, asynchronous
//               PB_LEVEL      - debounced button state (1 = pressed)
//               PRESS_PULSE   - 1-clock strobe on debounced press
//               RELEASE_PULSE - 1-clock strobe on debounced release
//               SHORT_PULSE   - 1-clock strobe when a short press is released
//               LONG_PULSE    - 1-clock strobe when a press becomes long
//               HOLD          - high while a long press is still held
//               PRESS_COUNT   - modulo-256 count of debounced presses
// Revision    : 1.0 - initial release
// ============================================================================
module pb_press_decoder #(
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PB_SW,
    output logic       PB_LEVEL,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic       SHORT_PULSE,
    output logic       LONG_PULSE,
    output logic       HOLD,
    output logic [7:0] PRESS_COUNT
);

    localparam logic [23:0] c_DEB_LAST = 24'(DEB_CYCLES - 1);
    // The hold counter is compared one step early so that LONG_PULSE lands on
    // the same edge at which the counter itself becomes LONG_CYCLES-1.
    localparam logic [27:0] c_HOLD_PRE = 28'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    logic        sync1_q;
    logic        sync2_q;
    logic [23:0] deb_cnt_q;
    logic [23:0] deb_cnt_d;
    logic        level_q;
    logic        level_d;
    logic        w_sync_pb;
    logic        w_differ;
    logic        w_accept;
    logic        w_press_acc;
    logic        w_release_acc;

    state_t      state_q;
    logic [27:0] hold_cnt_q;
    logic        press_q;
    logic        release_q;
    logic        short_q;
    logic        long_q;
    logic        hold_q;
    logic [7:0]  count_q;

    // Two-flop synchroniser; resets to the released (high) pin level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= PB_SW;
            sync2_q <= sync1_q;
        end
    end

    assign w_sync_pb = ~sync2_q;

    // Debounce: the counter only advances while the synchronised sample
    // disagrees with the accepted level, so any agreement restarts the wait.
    always_comb begin
        w_differ      = w_sync_pb ^ level_q;
        w_accept      = w_differ && (deb_cnt_q == c_DEB_LAST);
        deb_cnt_d     = (!w_differ || w_accept) ? 24'd0 : deb_cnt_q + 24'd1;
        level_d       = level_q ^ w_accept;
        w_press_acc   = w_accept && !level_q;
        w_release_acc = w_accept && level_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_cnt_q <= 24'd0;
            level_q   <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
        end
    end

    // Press classifier. A release checked ahead of the long threshold means
    // release wins when both happen on the same clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 28'd0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            hold_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_press_acc) begin
                        state_q    <= ST_PRESSED;
                        press_q    <= 1'b1;
                        hold_cnt_q <= 28'd0;
                        count_q    <= count_q + 8'd1;
                    end
                end
                ST_PRESSED: begin
                    if (w_release_acc) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                    end else if (hold_cnt_q == c_HOLD_PRE) begin
                        state_q    <= ST_LONG_HELD;
                        long_q     <= 1'b1;
                        hold_q     <= 1'b1;
                        hold_cnt_q <= hold_cnt_q + 28'd1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 28'd1;
                    end
                end
                ST_LONG_HELD: begin
                    if (w_release_acc) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        hold_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PB_LEVEL      = level_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign SHORT_PULSE   = short_q;
    assign LONG_PULSE    = long_q;
    assign HOLD          = hold_q;
    assign PRESS_COUNT   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_press_decoder
// Description : Directed bench for pb_press_decoder with DEB_CYCLES=4 and
//               LONG_CYCLES=20. Press scenarios come from a table; bounce,
//               reset-mid-press and counter wrap are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_press_decoder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PB_SW;
    logic       PB_LEVEL;
    logic       PRESS_PULSE;
    logic       RELEASE_PULSE;
    logic       SHORT_PULSE;
    logic       LONG_PULSE;
    logic       HOLD;
    logic [7:0] PRESS_COUNT;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] cnt_exp;

    pb_press_decoder #(
        .DEB_CYCLES  (4),
        .LONG_CYCLES (20)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PB_SW         (PB_SW),
        .PB_LEVEL      (PB_LEVEL),
        .PRESS_PULSE   (PRESS_PULSE),
        .RELEASE_PULSE (RELEASE_PULSE),
        .SHORT_PULSE   (SHORT_PULSE),
        .LONG_PULSE    (LONG_PULSE),
        .HOLD          (HOLD),
        .PRESS_COUNT   (PRESS_COUNT)
    );

    always #5 CLK = ~CLK;

    // One press scenario: pin low for low_len clocks, then high. When the
    // press is accepted it appears 6 clocks after the fall and the release
    // 6 clocks after the rise; long_at is the clock of LONG_PULSE (0 = none).
    typedef struct {
        int low_len;
        bit accepted;
        int long_at;
        bit is_short;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {PB_LEVEL, PRESS_PULSE, RELEASE_PULSE, SHORT_PULSE, LONG_PULSE, HOLD};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{low_len: 10, accepted: 1'b1, long_at: 0,  is_short: 1'b1}; // clean short
        vecs[1] = '{low_len: 40, accepted: 1'b1, long_at: 25, is_short: 1'b0}; // long press
        vecs[2] = '{low_len: 19, accepted: 1'b1, long_at: 0,  is_short: 1'b1}; // release == long edge
        vecs[3] = '{low_len: 20, accepted: 1'b1, long_at: 25, is_short: 1'b0}; // one clock later
        vecs[4] = '{low_len: 3,  accepted: 1'b0, long_at: 0,  is_short: 1'b0}; // glitch too short
        vecs[5] = '{low_len: 4,  accepted: 1'b1, long_at: 0,  is_short: 1'b1}; // minimum accepted

        // Reset state, both during reset and after release of reset.
        RESET   = 1'b1;
        PB_SW   = 1'b1;
        cnt_exp = 8'd0;
        #1;
        check("reset_outs_async", {26'd0, outs()}, 32'd0);
        check("reset_count_async", {24'd0, PRESS_COUNT}, 32'd0);
        tick();
        tick();
        RESET = 1'b0;
        tick();
        check("reset_outs", {26'd0, outs()}, 32'd0);
        check("reset_count", {24'd0, PRESS_COUNT}, 32'd0);

        // Table-driven press scenarios, checked every clock.
        for (int i = 0; i < 6; i++) begin
            int low;
            int rel;
            low = vecs[i].low_len;
            rel = low + 6;
            for (int t = 1; t <= low + 12; t++) begin
                logic [5:0] e;
                PB_SW = (t <= low) ? 1'b0 : 1'b1;
                tick();
                e = 6'd0;
                if (vecs[i].accepted) begin
                    e[5] = (t >= 6) && (t < rel);
                    e[4] = (t == 6);
                    e[3] = (t == rel);
                    e[2] = vecs[i].is_short && (t == rel);
                    e[1] = (vecs[i].long_at != 0) && (t == vecs[i].long_at);
                    e[0] = (vecs[i].long_at != 0) && (t >= vecs[i].long_at) && (t < rel);
                    if (t == 6) cnt_exp = cnt_exp + 8'd1;
                end
                check($sformatf("vec%0d_t%0d_outs", i, t), {26'd0, outs()}, {26'd0, e});
                check($sformatf("vec%0d_t%0d_count", i, t), {24'd0, PRESS_COUNT}, {24'd0, cnt_exp});
            end
        end

        // Bounce: toggling every 3 clocks never survives the debounce window.
        for (int t = 0; t < 30; t++) begin
            PB_SW = ((t / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("bounce_t%0d", t), {26'd0, outs()}, 32'd0);
        end
        PB_SW = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            check($sformatf("bounce_rest_t%0d", t), {26'd0, outs()}, 32'd0);
        end
        check("bounce_count", {24'd0, PRESS_COUNT}, {24'd0, cnt_exp});

        // Reset while in the long-held state with the button still down.
        begin
            bit found;
            found = 1'b0;
            PB_SW = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                tick();
                if (HOLD) found = 1'b1;
            end
            check("rst_reach_hold", {31'd0, found}, 32'd1);
        end
        #2;
        RESET = 1'b1;
        #1;
        check("rst_mid_outs", {26'd0, outs()}, 32'd0);
        check("rst_mid_count", {24'd0, PRESS_COUNT}, 32'd0);
        cnt_exp = 8'd0;
        tick();
        tick();
        RESET = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            logic [5:0] e;
            tick();
            e    = 6'd0;
            e[5] = (t >= 6);
            e[4] = (t == 6);
            if (t == 6) cnt_exp = cnt_exp + 8'd1;
            check($sformatf("rst_after_t%0d_outs", t), {26'd0, outs()}, {26'd0, e});
            check($sformatf("rst_after_t%0d_count", t), {24'd0, PRESS_COUNT}, {24'd0, cnt_exp});
        end
        PB_SW = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        check("rst_after_release_count", {24'd0, PRESS_COUNT}, 32'd1);

        // Wrap: 255 more presses brings the total since reset to 256.
        for (int p = 1; p <= 255; p++) begin
            PB_SW = 1'b0;
            for (int t = 0; t < 6; t++) tick();
            PB_SW = 1'b1;
            for (int t = 0; t < 6; t++) tick();
            cnt_exp = cnt_exp + 8'd1;
            check($sformatf("wrap_p%0d", p), {24'd0, PRESS_COUNT}, {24'd0, cnt_exp});
        end
        check("wrap_final_zero", {24'd0, PRESS_COUNT}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
